// File: rtl/rpll_ctrl_pkg.sv
// rpll_ctrl_pkg: shared types and constants for the rPLL supervisor.
package rpll_ctrl_pkg;

    typedef enum logic [2:0] {
        PRST,
        WAIT,
        REL,
        RUN,
        FAIL
    } state_t;

    typedef logic [5:0] div_code_t;

    // Power-on divider codes in raw rPLL encoding
    localparam div_code_t DEF_IDSEL_C  = 6'd0;
    localparam div_code_t DEF_FBDSEL_C = 6'd0;
    localparam div_code_t DEF_ODSEL_C  = 6'd0;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rpll_ctrl_lock_qual.sv
// lock_qual: brings the asynchronous rPLL LOCK into the clkin domain and
// qualifies it by requiring LOCK_FILTER consecutive high samples.
module lock_qual #(
    parameter int LOCK_FILTER = 256
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_lock,
    output logic o_lock_ok,
    output logic o_lock_lost
);

    localparam int FW = $clog2(LOCK_FILTER + 1);

    logic [1:0]    r_sync;
    logic [FW-1:0] r_filt;

    // Two-flop synchroniser for the raw lock input
    always_ff @(posedge clkin) begin
        if (!rst_n) r_sync <= 2'b00;
        else        r_sync <= {r_sync[0], i_lock};
    end

    // Consecutive-high counter; any low sample restarts it, and it saturates
    always_ff @(posedge clkin) begin
        if (!rst_n || i_clr || !r_sync[1])
            r_filt <= '0;
        else if (r_filt != FW'(LOCK_FILTER))
            r_filt <= r_filt + 1'b1;
    end

    assign o_lock_ok   = (r_filt == FW'(LOCK_FILTER));
    assign o_lock_lost = ~r_sync[1];

endmodule

// File: rtl/rpll_ctrl.sv
// rpll_ctrl: supervisor for a Gowin rPLL with dynamic dividers.
// Define RPLL_CTRL_DYN_EN to enable the cfg_* divider handshake; otherwise
// the divider codes stay at DEF_* and FAIL is left only through rst_n.
module rpll_ctrl
    import rpll_ctrl_pkg::*;
#(
    parameter int        RESET_CYCLES = 16,
    parameter int        LOCK_FILTER  = 256,
    parameter int        LOCK_TIMEOUT = 65535,
    parameter int        MAX_RETRY    = 3,
    parameter int        N_DOMAINS    = 2,
    parameter int        STAGGER      = 8,
    parameter div_code_t DEF_IDSEL    = DEF_IDSEL_C,
    parameter div_code_t DEF_FBDSEL   = DEF_FBDSEL_C,
    parameter div_code_t DEF_ODSEL    = DEF_ODSEL_C
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [5:0]           cfg_idsel,
    input  logic [5:0]           cfg_fbdsel,
    input  logic [5:0]           cfg_odsel,
    output logic                 pll_reset,
    output logic [5:0]           pll_idsel,
    output logic [5:0]           pll_fbdsel,
    output logic [5:0]           pll_odsel,
    input  logic                 pll_lock,
    output logic [N_DOMAINS-1:0] dom_rst_n,
    output logic                 locked,
    output logic                 fail,
    output logic [1:0]           retry_cnt
);

    // One shared counter serves the reset pulse, the timeout and the stagger
    localparam int REL_SPAN = (N_DOMAINS - 1) * STAGGER;
    localparam int CW = $clog2(maxOf(maxOf(RESET_CYCLES, LOCK_TIMEOUT), REL_SPAN) + 1);
    localparam logic [CW-1:0] C_RST_END = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] C_TO_END  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] C_REL_END = CW'(REL_SPAN);

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_cnt;
    logic [1:0]            r_retry;
    logic                  w_timeout;
    logic                  w_lock_ok;
    logic                  w_lock_lost;
    logic                  w_ready;
    logic                  w_xfer;
    logic [N_DOMAINS-1:0]  w_dom;

    lock_qual #(
        .LOCK_FILTER(LOCK_FILTER)
    ) u_lock_qual (
        .clkin       (clkin),
        .rst_n       (rst_n),
        .i_clr       (r_state != WAIT),
        .i_lock      (pll_lock),
        .o_lock_ok   (w_lock_ok),
        .o_lock_lost (w_lock_lost)
    );

`ifdef RPLL_CTRL_DYN_EN
    div_code_t r_idsel;
    div_code_t r_fbdsel;
    div_code_t r_odsel;

    assign w_ready = (r_state == RUN) || (r_state == FAIL);
    assign w_xfer  = cfg_valid && w_ready;

    // Latch the offered divider codes on each accepted transfer
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_idsel  <= DEF_IDSEL;
            r_fbdsel <= DEF_FBDSEL;
            r_odsel  <= DEF_ODSEL;
        end else if (w_xfer) begin
            r_idsel  <= cfg_idsel;
            r_fbdsel <= cfg_fbdsel;
            r_odsel  <= cfg_odsel;
        end
    end

    assign pll_idsel  = r_idsel;
    assign pll_fbdsel = r_fbdsel;
    assign pll_odsel  = r_odsel;
`else
    logic w_unused;

    assign w_unused   = ^{cfg_valid, cfg_idsel, cfg_fbdsel, cfg_odsel};
    assign w_ready    = 1'b0;
    assign w_xfer     = 1'b0;
    assign pll_idsel  = DEF_IDSEL;
    assign pll_fbdsel = DEF_FBDSEL;
    assign pll_odsel  = DEF_ODSEL;
`endif

    // Next-state decode; an accepted transfer overrides everything else
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            PRST: if (r_cnt == C_RST_END) w_next = WAIT;
            WAIT: begin
                if (w_lock_ok) begin
                    w_next = REL;
                end else if (r_cnt == C_TO_END) begin
                    w_timeout = 1'b1;
                    w_next = ((r_retry + 2'd1) == 2'(MAX_RETRY)) ? FAIL : PRST;
                end
            end
            REL: begin
                if (w_lock_lost)             w_next = PRST;
                else if (r_cnt == C_REL_END) w_next = RUN;
            end
            RUN:  if (w_lock_lost) w_next = PRST;
            FAIL: w_next = FAIL;
            default: w_next = PRST;
        endcase
        if (w_xfer) w_next = PRST;
    end

    // State register plus a counter that restarts on every state entry
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_state <= PRST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Failed-attempt count: bumped on timeout, cleared on lock or transfer
    always_ff @(posedge clkin) begin
        if (!rst_n || w_xfer)
            r_retry <= 2'd0;
        else if (w_timeout)
            r_retry <= r_retry + 2'd1;
        else if (r_state == WAIT && w_next == REL)
            r_retry <= 2'd0;
    end

    // Staggered domain release: bit i opens i*STAGGER cycles into REL
    always_comb begin
        w_dom = '0;
        for (int i = 0; i < N_DOMAINS; i++) begin
            if (r_state == RUN || (r_state == REL && r_cnt >= CW'(i * STAGGER)))
                w_dom[i] = 1'b1;
        end
    end

    assign dom_rst_n = w_dom;
    assign pll_reset = (r_state == PRST) || (r_state == FAIL);
    assign locked    = (r_state == REL) || (r_state == RUN);
    assign fail      = (r_state == FAIL);
    assign retry_cnt = r_retry;
    assign cfg_ready = w_ready;

endmodule

// File: tb/tb_rpll_ctrl.sv
// tb_rpll_ctrl: scoreboard bench for rpll_ctrl. Stimulus pushes the expected
// output snapshot and the cycle it should appear in; the monitor pops one entry
// each time any observed output changes.
module tb_rpll_ctrl;

    localparam int RESET_CYCLES = 4;
    localparam int LOCK_FILTER  = 8;
    localparam int LOCK_TIMEOUT = 100;
    localparam int MAX_RETRY    = 2;
    localparam int N_DOMAINS    = 3;
    localparam int STAGGER      = 2;
    localparam logic [5:0] DI = 6'd1;
    localparam logic [5:0] DF = 6'd2;
    localparam logic [5:0] DO = 6'd3;
`ifdef RPLL_CTRL_DYN_EN
    localparam logic RDY_FAIL = 1'b1;
`else
    localparam logic RDY_FAIL = 1'b0;
`endif

    logic       clkin = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [5:0] cfg_idsel = 6'd0;
    logic [5:0] cfg_fbdsel = 6'd0;
    logic [5:0] cfg_odsel = 6'd0;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       pll_lock = 1'b0;
    logic [2:0] dom_rst_n;
    logic       locked, fail;
    logic [1:0] retry_cnt;

    typedef logic [26:0] snap_t;
    typedef struct {
        int    cyc;
        snap_t s;
    } exp_t;

    exp_t  expQ[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    t0 = 0;
    snap_t snapNow;
    snap_t rstSnap;

    always #5 clkin = ~clkin;

    always @(posedge clkin) cyc <= cyc + 1;

    rpll_ctrl #(
        .RESET_CYCLES(RESET_CYCLES), .LOCK_FILTER(LOCK_FILTER),
        .LOCK_TIMEOUT(LOCK_TIMEOUT), .MAX_RETRY(MAX_RETRY),
        .N_DOMAINS(N_DOMAINS), .STAGGER(STAGGER),
        .DEF_IDSEL(DI), .DEF_FBDSEL(DF), .DEF_ODSEL(DO)
    ) dut (
        .clkin(clkin), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
        .pll_reset(pll_reset),
        .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
        .pll_lock(pll_lock), .dom_rst_n(dom_rst_n),
        .locked(locked), .fail(fail), .retry_cnt(retry_cnt)
    );

    assign snapNow = {pll_reset, locked, fail, retry_cnt, dom_rst_n, cfg_ready,
                      pll_idsel, pll_fbdsel, pll_odsel};

    function automatic snap_t mk(input logic prst, input logic lck, input logic fl,
                                 input logic [1:0] rc, input logic [2:0] dom,
                                 input logic rdy, input logic [5:0] i,
                                 input logic [5:0] f, input logic [5:0] o);
        return {prst, lck, fl, rc, dom, rdy, i, f, o};
    endfunction

    task automatic push(input int c, input snap_t s);
        exp_t e;
        e.cyc = c;
        e.s   = s;
        expQ.push_back(e);
    endtask

    task automatic waitCyc(input int t);
        while (cyc < t) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic lock, input logic valid,
                                 input logic [5:0] i, input logic [5:0] f,
                                 input logic [5:0] o);
        pll_lock   = lock;
        cfg_valid  = valid;
        cfg_idsel  = i;
        cfg_fbdsel = f;
        cfg_odsel  = o;
    endtask

    task automatic checkOutput(input snap_t s);
        exp_t e;
        total++;
        if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_change cyc=%0d got=%h", cyc, s);
        end else begin
            e = expQ.pop_front();
            if (e.cyc != cyc || e.s !== s) begin
                bad++;
                $display("[TB] FAIL snapshot cyc=%0d got=%h required cyc=%0d val=%h",
                         cyc, s, e.cyc, e.s);
            end
        end
    endtask

    task automatic doReset();
        int ts;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
        ts = cyc;
        push(ts + 1, rstSnap);
        waitCyc(ts + 3);
        rst_n = 1'b1;
        t0 = cyc;
    endtask

    // Monitor: compare every change of the observed output bundle
    initial begin
        snap_t prev;
        prev = 'x;
        forever begin
            @(negedge clkin);
            if (snapNow !== prev) checkOutput(snapNow);
            prev = snapNow;
        end
    end

    initial begin
        #60000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int L, C, F;
        rstSnap = mk(1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, DI, DF, DO);

        // Power-on reset, then a clean lock 10 cycles after release
        push(1, rstSnap);
        repeat (3) @(posedge clkin);
        #1;
        rst_n = 1'b1;
        t0 = cyc;
        push(t0 + 4,  mk(0, 0, 0, 2'd0, 3'b000, 0, DI, DF, DO));
        push(t0 + 21, mk(0, 1, 0, 2'd0, 3'b001, 0, DI, DF, DO));
        push(t0 + 23, mk(0, 1, 0, 2'd0, 3'b011, 0, DI, DF, DO));
        push(t0 + 25, mk(0, 1, 0, 2'd0, 3'b111, 0, DI, DF, DO));
`ifdef RPLL_CTRL_DYN_EN
        push(t0 + 26, mk(0, 1, 0, 2'd0, 3'b111, 1, DI, DF, DO));
`endif
        waitCyc(t0 + 10);
        applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 6'd0);
        waitCyc(t0 + 30);

        // Glitchy lock: 5 high, 1 low, then 8 more highs needed
        doReset();
        push(t0 + 4,  mk(0, 0, 0, 2'd0, 3'b000, 0, DI, DF, DO));
        push(t0 + 27, mk(0, 1, 0, 2'd0, 3'b001, 0, DI, DF, DO));
        push(t0 + 29, mk(0, 1, 0, 2'd0, 3'b011, 0, DI, DF, DO));
        push(t0 + 31, mk(0, 1, 0, 2'd0, 3'b111, 0, DI, DF, DO));
`ifdef RPLL_CTRL_DYN_EN
        push(t0 + 32, mk(0, 1, 0, 2'd0, 3'b111, 1, DI, DF, DO));
`endif
        waitCyc(t0 + 10);
        applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 6'd0);
        waitCyc(t0 + 15);
        applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
        waitCyc(t0 + 16);
        applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 6'd0);
        waitCyc(t0 + 36);

        // One-cycle lock drop in RUN, followed by a re-lock without a retry
        L = cyc;
        push(L + 3,  mk(1, 0, 0, 2'd0, 3'b000, 0, DI, DF, DO));
        push(L + 7,  mk(0, 0, 0, 2'd0, 3'b000, 0, DI, DF, DO));
        push(L + 16, mk(0, 1, 0, 2'd0, 3'b001, 0, DI, DF, DO));
        push(L + 18, mk(0, 1, 0, 2'd0, 3'b011, 0, DI, DF, DO));
        push(L + 20, mk(0, 1, 0, 2'd0, 3'b111, 0, DI, DF, DO));
`ifdef RPLL_CTRL_DYN_EN
        push(L + 21, mk(0, 1, 0, 2'd0, 3'b111, 1, DI, DF, DO));
`endif
        applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
        waitCyc(L + 1);
        applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 6'd0);
        waitCyc(L + 25);

`ifdef RPLL_CTRL_DYN_EN
        // Reconfigure in RUN; an offer made during WAIT waits for RUN
        C = cyc;
        push(C + 1,  mk(1, 0, 0, 2'd0, 3'b000, 0, 6'd3, 6'd9, 6'd4));
        push(C + 5,  mk(0, 0, 0, 2'd0, 3'b000, 0, 6'd3, 6'd9, 6'd4));
        push(C + 14, mk(0, 1, 0, 2'd0, 3'b001, 0, 6'd3, 6'd9, 6'd4));
        push(C + 16, mk(0, 1, 0, 2'd0, 3'b011, 0, 6'd3, 6'd9, 6'd4));
        push(C + 18, mk(0, 1, 0, 2'd0, 3'b111, 0, 6'd3, 6'd9, 6'd4));
        push(C + 19, mk(0, 1, 0, 2'd0, 3'b111, 1, 6'd3, 6'd9, 6'd4));
        push(C + 20, mk(1, 0, 0, 2'd0, 3'b000, 0, 6'd7, 6'd7, 6'd7));
        applyStimulus(1'b1, 1'b1, 6'd3, 6'd9, 6'd4);
        waitCyc(C + 1);
        applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 6'd0);
        waitCyc(C + 6);
        applyStimulus(1'b1, 1'b1, 6'd7, 6'd7, 6'd7);
        waitCyc(C + 20);
        applyStimulus(1'b1, 1'b0, 6'd0, 6'd0, 6'd0);
`endif

        // Lock never arrives: two timed-out attempts, then FAIL
        doReset();
        push(t0 + 4,   mk(0, 0, 0, 2'd0, 3'b000, 0, DI, DF, DO));
        push(t0 + 104, mk(1, 0, 0, 2'd1, 3'b000, 0, DI, DF, DO));
        push(t0 + 108, mk(0, 0, 0, 2'd1, 3'b000, 0, DI, DF, DO));
        push(t0 + 208, mk(1, 0, 1, 2'd2, 3'b000, RDY_FAIL, DI, DF, DO));
        waitCyc(t0 + 215);

`ifdef RPLL_CTRL_DYN_EN
        // A transfer in FAIL clears fail/retry and starts a fresh attempt
        F = cyc;
        push(F + 1, mk(1, 0, 0, 2'd0, 3'b000, 0, 6'd5, 6'd6, 6'd7));
        push(F + 5, mk(0, 0, 0, 2'd0, 3'b000, 0, 6'd5, 6'd6, 6'd7));
        applyStimulus(1'b0, 1'b1, 6'd5, 6'd6, 6'd7);
        waitCyc(F + 1);
        applyStimulus(1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
        waitCyc(F + 10);
`else
        // Offers are ignored and FAIL holds until rst_n
        F = cyc;
        applyStimulus(1'b0, 1'b1, 6'd5, 6'd6, 6'd7);
        waitCyc(F + 25);
        doReset();
        waitCyc(t0 + 2);
`endif

        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL missing_changes left=%0d required=0 next_cyc=%0d",
                     expQ.size(), expQ[0].cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
